// File: rtl/matrix_mem_arbiter.sv
// Round-robin arbiter sharing one matrix register-file port between host, multiplier and adder.
// Define MATRIX_ARB_TIMEOUT_EN to bound READ at 255 cycles and raise a sticky out_error.
module matrix_mem_arbiter #(
    parameter int address_width = 4,
    parameter int cell_width    = 8,
    parameter int size          = 4,
    parameter int width         = cell_width * size
) (
    input  logic                       in_clk,
    input  logic                       in_reset,
    input  logic [2:0]                 in_req_read_en,
    input  logic [2:0]                 in_req_write_en,
    input  logic [3*address_width-1:0] in_req_address,
    input  logic [5:0]                 in_req_type,
    input  logic [5:0]                 in_req_matrix,
    input  logic [3*width-1:0]         in_req_wdata,
    output logic [2:0]                 out_grant,
    output logic [2:0]                 out_req_done,
    output logic [width-1:0]           out_req_rdata,
    output logic [address_width-1:0]   out_reg_address,
    output logic [1:0]                 out_type,
    output logic [1:0]                 out_matrix,
    output logic                       out_read_en,
    output logic                       out_write_en,
    output logic [width-1:0]           out_cell_c,
    input  logic [width-1:0]           in_data,
    input  logic                       in_data_ready,
    output logic                       out_error
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t                     r_state, w_next_state;
    logic [1:0]                 r_last_grant, r_owner;
    logic [1:0]                 w_sel, w_owner_n;
    logic                       w_sel_valid, w_timeout;
    logic [2:0]                 w_active;
    logic [2:0]                 w_grant_nxt, w_done_nxt;
    logic [width-1:0]           w_rdata_nxt, w_cell_nxt;
    logic [address_width-1:0]   w_address_nxt;
    logic [1:0]                 w_type_nxt, w_matrix_nxt;

    function automatic logic [1:0] rr_index(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    assign w_active = in_req_read_en | in_req_write_en;

    // Walk the search order backwards so the requester nearest last_grant+1 wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_sel       = 2'd0;
        w_sel_valid = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            logic [1:0] idx;
            idx = rr_index(r_last_grant, 2'(k));
            if (w_active[idx]) begin
                w_sel       = idx;
                w_sel_valid = 1'b1;
            end
        end
    end

`ifdef MATRIX_ARB_TIMEOUT_EN
    logic [7:0] r_timer;
    logic       r_error;
    assign w_timeout = (r_state == S_READ) && !in_data_ready && (r_timer == 8'd254);
    assign out_error = r_error;
`else
    assign w_timeout = 1'b0;
    assign out_error = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_sel_valid) w_next_state = in_req_write_en[w_sel] ? S_WRITE : S_READ;
            S_WRITE: w_next_state = S_DONE;
            S_READ:  if (in_data_ready || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output registers are loaded from the next state, so they line up with the state they describe.
    always_comb begin
        w_owner_n     = (r_state == S_IDLE) ? w_sel : r_owner;
        w_grant_nxt   = (w_next_state != S_IDLE) ? (3'b001 << w_owner_n) : 3'b000;
        w_done_nxt    = (w_next_state == S_DONE) ? (3'b001 << w_owner_n) : 3'b000;
        w_rdata_nxt   = (r_state == S_READ && in_data_ready) ? in_data : '0;
        w_cell_nxt    = '0;
        w_address_nxt = '0;
        w_type_nxt    = 2'b00;
        w_matrix_nxt  = 2'b00;
        if (w_next_state == S_WRITE || w_next_state == S_READ) begin
            if (r_state == S_IDLE) begin
                w_address_nxt = in_req_address[w_sel*address_width +: address_width];
                w_type_nxt    = in_req_type[w_sel*2 +: 2];
                w_matrix_nxt  = in_req_matrix[w_sel*2 +: 2];
            end else begin
                w_address_nxt = out_reg_address;
                w_type_nxt    = out_type;
                w_matrix_nxt  = out_matrix;
            end
        end
        if (w_next_state == S_WRITE)
            w_cell_nxt = in_req_wdata[w_sel*width +: width];
    end

    always_ff @(posedge in_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (in_reset) begin
            r_state         <= S_IDLE;
            r_last_grant    <= 2'd2;
            r_owner         <= 2'd0;
            out_grant       <= 3'b000;
            out_req_done    <= 3'b000;
            out_req_rdata   <= '0;
            out_reg_address <= '0;
            out_type        <= 2'b00;
            out_matrix      <= 2'b00;
            out_read_en     <= 1'b0;
            out_write_en    <= 1'b0;
            out_cell_c      <= '0;
`ifdef MATRIX_ARB_TIMEOUT_EN
            r_timer         <= 8'd0;
            r_error         <= 1'b0;
`endif
        end else begin
            r_state         <= w_next_state;
            r_owner         <= w_owner_n;
            if (r_state == S_DONE)
                r_last_grant <= r_owner;
            out_grant       <= w_grant_nxt;
            out_req_done    <= w_done_nxt;
            out_req_rdata   <= w_rdata_nxt;
            out_reg_address <= w_address_nxt;
            out_type        <= w_type_nxt;
            out_matrix      <= w_matrix_nxt;
            out_read_en     <= (w_next_state == S_READ);
            out_write_en    <= (w_next_state == S_WRITE);
            out_cell_c      <= w_cell_nxt;
`ifdef MATRIX_ARB_TIMEOUT_EN
            r_timer         <= (r_state == S_READ) ? r_timer + 8'd1 : 8'd0;
            if (w_timeout)
                r_error <= 1'b1;
`endif
        end
    end

endmodule
